// File: rtl/max_reduce_sequencer.sv
// -----------------------------------------------------------------------------
// max_reduce_sequencer
//
// Purpose:
//   Finds the maximum of a vector of CHANNELS IEEE-754 single-precision
//   Q-values, and optionally the index of that maximum. One bank of pairwise
//   comparators is reused over several rounds. Each round halves the live
//   element count, and an odd leftover element passes through unchanged.
//
// Optional feature (macro MAX_REDUCE_ARGMAX_EN):
//   When defined, index tags travel with each value and o_index is present.
//   When undefined, there are no tag registers and no o_index port.
//   Value reduction, timing and handshakes are the same in both builds.
//
// Handshakes (valid/ready):
//   - A transfer happens on a rising edge where valid && ready are both high.
//   - A source holds valid, and its payload, until that edge.
//   - o_ready is high only in IDLE. i_data is sampled only at acceptance.
//   - o_valid, o_data and o_index stay stable until the edge where i_ready
//     is high. That edge ends the result transfer.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   i_valid      request valid
//   o_ready      block can accept a request (state == IDLE)
//   i_data       CHANNELS packed values; element k is at [DW*(k+1)-1 : DW*k]
//   o_valid      result valid
//   i_ready      downstream accepts the result
//   o_data       maximum value
//   o_index      index of the maximum (only with MAX_REDUCE_ARGMAX_EN)
//   o_busy       high in REDUCE or DONE
//   o_dbg_state  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module max_reduce_sequencer #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
`ifdef MAX_REDUCE_ARGMAX_EN
  output logic [IDX_WIDTH-1:0]           o_index,
`endif
  output logic                           o_busy,
  output logic [1:0]                     o_dbg_state
);

  localparam int NSLOT = (CHANNELS + 1) / 2;
  localparam int CNT_W = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_buf [CHANNELS];

  logic [DATA_WIDTH-1:0] w_nbuf   [NSLOT];
  logic                  w_take_b [NSLOT];
  logic [CNT_W:0]        w_cnt_inc;
  logic [CNT_W-1:0]      w_cnt_next;

`ifdef MAX_REDUCE_ARGMAX_EN
  logic [IDX_WIDTH-1:0]  r_index;
  logic [IDX_WIDTH-1:0]  r_tag  [CHANNELS];
  logic [IDX_WIDTH-1:0]  w_ntag [NSLOT];
`endif

  // Returns 1 when a is strictly greater than b under the sign-magnitude order.
  // +0 and -0 compare equal. NaN and Inf are ordered by their raw bits.
  function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
    logic both_zero;
    both_zero = (a[DATA_WIDTH-2:0] == '0) && (b[DATA_WIDTH-2:0] == '0);
    if (both_zero)
      return 1'b0;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      return b[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])
      return a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
    else
      return a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
  endfunction

  // ceil(count/2). The extra bit keeps count+1 from overflowing.
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_cnt_next = w_cnt_inc[CNT_W:1];

  // One comparator per output slot.
  // Slot j takes buf[2j+1] only if that element is live and strictly larger.
  // On a tie buf[2j] wins, so the lowest original index survives.
  // When buf[2j+1] is not live, buf[2j] passes through unchanged. This covers
  // the odd leftover, which sits at buf[count-1] = buf[2*(count/2)].
  for (genvar j = 0; j < NSLOT; j++) begin : g_slot
    if (2 * j + 1 < CHANNELS) begin : g_pair
      logic w_pair_live;
      assign w_pair_live = (CNT_W'(2 * j + 1) < r_cnt);
      assign w_take_b[j] = w_pair_live && fp_gt(r_buf[2*j+1], r_buf[2*j]);
      assign w_nbuf[j]   = w_take_b[j] ? r_buf[2*j+1] : r_buf[2*j];
`ifdef MAX_REDUCE_ARGMAX_EN
      assign w_ntag[j]   = w_take_b[j] ? r_tag[2*j+1] : r_tag[2*j];
`endif
    end else begin : g_single
      assign w_take_b[j] = 1'b0;
      assign w_nbuf[j]   = r_buf[2*j];
`ifdef MAX_REDUCE_ARGMAX_EN
      assign w_ntag[j]   = r_tag[2*j];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
`ifdef MAX_REDUCE_ARGMAX_EN
      r_index <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            for (int k = 0; k < CHANNELS; k++) begin
              r_buf[k] <= i_data[DATA_WIDTH*k +: DATA_WIDTH];
`ifdef MAX_REDUCE_ARGMAX_EN
              r_tag[k] <= IDX_WIDTH'(k);
`endif
            end
            r_cnt   <= CNT_W'(CHANNELS);
            r_state <= (CHANNELS == 1) ? S_DONE : S_REDUCE;
          end
        end
        S_REDUCE: begin
          for (int j = 0; j < NSLOT; j++) begin
            r_buf[j] <= w_nbuf[j];
`ifdef MAX_REDUCE_ARGMAX_EN
            r_tag[j] <= w_ntag[j];
`endif
          end
          r_cnt <= w_cnt_next;
          if (w_cnt_next == CNT_W'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          // The first DONE cycle copies the result into the output registers.
          // This gives o_valid its one-cycle lag after the last round.
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_data  <= r_buf[0];
`ifdef MAX_REDUCE_ARGMAX_EN
            r_index <= r_tag[0];
`endif
          end else if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_dbg_state = r_state;
`ifdef MAX_REDUCE_ARGMAX_EN
  assign o_index     = r_index;
`endif

endmodule

// File: tb/tb_max_reduce_sequencer.sv
// -----------------------------------------------------------------------------
// tb_max_reduce_sequencer
//
// Drives three instances of max_reduce_sequencer, with CHANNELS = 4, 5 and 1.
// Directed vectors and random vectors are sent through the valid/ready
// handshake. Expected values come from a linear-scan reference model that
// uses signed magnitude keys.
// -----------------------------------------------------------------------------
module tb_max_reduce_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT wiring (index 0: CH=4, 1: CH=5, 2: CH=1) ----------------
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_ready [3];
  logic         out_valid [3];
  logic         out_busy  [3];
  logic [31:0]  out_data  [3];
  logic [1:0]   dbg_state [3];
  logic [127:0] data4;
  logic [159:0] data5;
  logic [31:0]  data1;
`ifdef MAX_REDUCE_ARGMAX_EN
  logic [1:0]   idx4;
  logic [2:0]   idx5;
  logic [0:0]   idx1;
  int           out_idx [3];
  assign out_idx[0] = int'(idx4);
  assign out_idx[1] = int'(idx5);
  assign out_idx[2] = int'(idx1);
`endif

  max_reduce_sequencer #(.CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
    .i_data(data4), .o_valid(out_valid[0]), .i_ready(in_ready[0]),
    .o_data(out_data[0]),
`ifdef MAX_REDUCE_ARGMAX_EN
    .o_index(idx4),
`endif
    .o_busy(out_busy[0]), .o_dbg_state(dbg_state[0])
  );

  max_reduce_sequencer #(.CHANNELS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
    .i_data(data5), .o_valid(out_valid[1]), .i_ready(in_ready[1]),
    .o_data(out_data[1]),
`ifdef MAX_REDUCE_ARGMAX_EN
    .o_index(idx5),
`endif
    .o_busy(out_busy[1]), .o_dbg_state(dbg_state[1])
  );

  max_reduce_sequencer #(.CHANNELS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(in_valid[2]), .o_ready(out_ready[2]),
    .i_data(data1), .o_valid(out_valid[2]), .i_ready(in_ready[2]),
    .o_data(out_data[2]),
`ifdef MAX_REDUCE_ARGMAX_EN
    .o_index(idx1),
`endif
    .o_busy(out_busy[2]), .o_dbg_state(dbg_state[2])
  );

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] cur_vec [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nch(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 5 : 1;
  endfunction

  // Reference model: linear scan over sign-magnitude keys.
  // Only a strictly larger key replaces the current best, so the first
  // occurrence of the maximum is kept. Both zeros map to key 0.
  function automatic longint fkey(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  task automatic model(input int n, output logic [31:0] md, output int mi);
    md = cur_vec[0];
    mi = 0;
    for (int k = 1; k < n; k++) begin
      if (fkey(cur_vec[k]) > fkey(md)) begin
        md = cur_vec[k];
        mi = k;
      end
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h4000_0000;
      3:       return 32'hC000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_data(input int sel);
    case (sel)
      0:       for (int k = 0; k < 4; k++) data4[32*k +: 32] = cur_vec[k];
      1:       for (int k = 0; k < 5; k++) data5[32*k +: 32] = cur_vec[k];
      default: data1 = cur_vec[0];
    endcase
  endtask

  task automatic scramble_data(input int sel);
    case (sel)
      0:       for (int k = 0; k < 4; k++) data4[32*k +: 32] = $urandom;
      1:       for (int k = 0; k < 5; k++) data5[32*k +: 32] = $urandom;
      default: data1 = $urandom;
    endcase
  endtask

  task automatic set_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [31:0] e);
    cur_vec[0] = a; cur_vec[1] = b; cur_vec[2] = c; cur_vec[3] = d; cur_vec[4] = e;
  endtask

  // Sends cur_vec to instance sel and checks the latency, the result, the
  // stability under backpressure for 'hold' cycles, and the handoff.
  task automatic run_req(input int sel, input int hold, input bit use_model,
                         input logic [31:0] xd, input int xi, input string name);
    int          n;
    int          cyc;
    logic [31:0] ed;
    logic [31:0] got_d;
    int          ei;
    n = nch(sel);
    if (use_model) model(n, ed, ei);
    else begin ed = xd; ei = xi; end
    exp_q.push_back(ed);

    @(negedge clk);
    drive_data(sel);
    in_valid[sel] = 1'b1;
    cyc = 0;
    while (!out_ready[sel] && cyc < 20) begin @(negedge clk); cyc++; end
    check({name, "_ready_idle"}, 32'(out_ready[sel]), 32'd1);

    @(negedge clk);                 // acceptance edge has passed
    in_valid[sel] = 1'b0;
    scramble_data(sel);             // must be ignored from here on
    check({name, "_busy_after_accept"}, 32'(out_busy[sel]), 32'd1);
    check({name, "_ready_low_busy"}, 32'(out_ready[sel]), 32'd0);

    cyc = 0;
    while (!out_valid[sel] && cyc < 40) begin @(negedge clk); cyc++; end
    check({name, "_latency"}, 32'(cyc), 32'($clog2(n) + 1));

    got_d = exp_q.pop_front();
    check({name, "_data"}, out_data[sel], got_d);
`ifdef MAX_REDUCE_ARGMAX_EN
    check({name, "_index"}, 32'(out_idx[sel]), 32'(ei));
`endif

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(out_valid[sel]), 32'd1);
      check({name, "_hold_data"}, out_data[sel], got_d);
      check({name, "_hold_ready"}, 32'(out_ready[sel]), 32'd0);
`ifdef MAX_REDUCE_ARGMAX_EN
      check({name, "_hold_index"}, 32'(out_idx[sel]), 32'(ei));
`endif
    end

    in_ready[sel] = 1'b1;
    @(negedge clk);
    in_ready[sel] = 1'b0;
    check({name, "_handoff_valid"}, 32'(out_valid[sel]), 32'd0);
    check({name, "_handoff_ready"}, 32'(out_ready[sel]), 32'd1);
    check({name, "_handoff_busy"}, 32'(out_busy[sel]), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid[s] = 1'b0;
      in_ready[s] = 1'b0;
    end
    data4 = '0; data5 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_valid%0d", s), 32'(out_valid[s]), 32'd0);
      check($sformatf("reset_data%0d", s), out_data[s], 32'd0);
      check($sformatf("reset_busy%0d", s), 32'(out_busy[s]), 32'd0);
      check($sformatf("reset_ready%0d", s), 32'(out_ready[s]), 32'd1);
`ifdef MAX_REDUCE_ARGMAX_EN
      check($sformatf("reset_index%0d", s), 32'(out_idx[s]), 32'd0);
`endif
    end
    rst_n = 1'b1;

    set_vec(32'h3F80_0000, 32'h4000_0000, 32'hC040_0000, 32'h3F00_0000, 32'h0);
    run_req(0, 0, 1'b0, 32'h4000_0000, 1, "ch4_basic");

    set_vec(32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000, 32'hC080_0000, 32'h4040_0000);
    run_req(1, 0, 1'b0, 32'h4040_0000, 4, "ch5_odd");

    set_vec(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h0);
    run_req(0, 0, 1'b0, 32'h4000_0000, 0, "ch4_tie");

    set_vec(32'h0000_0000, 32'h8000_0000, 32'hBF80_0000, 32'hBF80_0000, 32'h0);
    run_req(0, 0, 1'b0, 32'h0000_0000, 0, "ch4_zero_tie");

    set_vec(32'hBF00_0000, 32'hC000_0000, 32'h3E80_0000, 32'h3E80_0000, 32'h0);
    run_req(0, 5, 1'b0, 32'h3E80_0000, 2, "ch4_backpressure");

    // Reset during the second REDUCE round.
    set_vec(32'h4100_0000, 32'h3F80_0000, 32'h4200_0000, 32'h0, 32'h0);
    @(negedge clk);
    drive_data(0);
    in_valid[0] = 1'b1;
    check("rst_pre_ready", 32'(out_ready[0]), 32'd1);
    @(negedge clk);                 // accepted; first round runs next edge
    in_valid[0] = 1'b0;
    @(negedge clk);                 // first round done; second round in flight
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_valid", 32'(out_valid[0]), 32'd0);
    check("rst_mid_busy", 32'(out_busy[0]), 32'd0);
    check("rst_mid_ready", 32'(out_ready[0]), 32'd1);

    set_vec(32'h3F00_0000, 32'h3F80_0000, 32'h0, 32'h0, 32'h0);
    run_req(0, 0, 1'b0, 32'h3F80_0000, 1, "ch4_after_reset");

    set_vec(32'hC040_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    run_req(2, 0, 1'b0, 32'hC040_0000, 0, "ch1_single");

    // Random vectors against the reference model.
    for (int it = 0; it < 10; it++) begin
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < 5; k++) cur_vec[k] = rand_val();
        run_req(s, $urandom_range(0, 3), 1'b1, 32'h0, 0, $sformatf("rand%0d_%0d", it, s));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_reduce_sequencer.md
Name: max_reduce_sequencer

Overview:
- Sequential controller that reduces a vector of CHANNELS floating-point Q-values to its maximum and the index of that maximum.
- Reuses one bank of pairwise max comparators over several rounds instead of building a full combinational max tree.
- Each round halves the live element count; an odd leftover element passes through to the next round.
- Sits between the Q-table read port and the action-select/update logic, with valid/ready handshakes on both sides.

Parameters:
- CHANNELS, 4, number of Q-values per request; legal range 1..64.
- DATA_WIDTH, 32 (shared params include), width of one IEEE-754 single value.
- IDX_WIDTH, derived as max(1, clog2(CHANNELS)), width of the argmax index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request.
- i_data  input  DATA_WIDTH*CHANNELS  Q-value vector; element k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_data  output  DATA_WIDTH  maximum value.
- o_index  output  IDX_WIDTH  index of the maximum (present only with the optional feature).
- o_busy  output  1  high in REDUCE or DONE.

Behaviour:
- Reset: when rst_n is low at a clk edge, go to IDLE; o_valid=0, o_data=0, o_index=0, o_busy=0, live count=0. Reset mid-operation discards the current request with no output.
- o_ready = (state==IDLE). Acceptance happens on a cycle with i_valid && o_ready.
- IDLE: on acceptance, latch all CHANNELS elements into the working buffer and set each element's index tag to k. Set count=CHANNELS.
  - If CHANNELS==1, go to DONE.
  - Otherwise go to REDUCE.
- REDUCE, one round per cycle:
  - Slot j gets max(buf[2j], buf[2j+1]) for j < count/2. The tag of the winning element goes with it.
  - If count is odd, slot count/2 gets buf[count-1] unchanged.
  - New count = ceil(count/2). When the new count reaches 1, go to DONE.
- Number of rounds R = clog2(CHANNELS). o_valid rises R+1 cycles after the acceptance edge. Example: CHANNELS=4 gives R=2 and o_valid on cycle 3.
- DONE:
  - o_valid=1. o_data=buf[0] and o_index=tag[0] are held stable while i_ready is low.
  - On o_valid && i_ready, go to IDLE and drop o_valid on the next cycle.
  - No back-to-back acceptance in the same cycle as result handoff: o_ready stays low in DONE.
- Compare rule, combinational and sign-magnitude:
  - Signs differ: the positive operand wins.
  - Both positive: the larger magnitude wins.
  - Both negative: the smaller magnitude wins.
  - +0 and -0 compare equal.
  - NaN/Inf are treated as raw bit patterns; no special handling.
- Tie (equal compare): the lower-indexed operand (buf[2j]) wins, so the smallest original index of the maximum is reported.
- i_data is sampled only at acceptance. Changes on i_data during REDUCE or DONE are ignored.
- i_valid while busy is ignored; the requester must hold it until o_ready.

Optional Feature:
- Macro: MAX_REDUCE_ARGMAX_EN.
- Defined: index tags are tracked and the o_index port exists, driven as specified above.
- Undefined: no tag registers and no o_index port. Value reduction, timing and handshake are identical.

Test Plan:
- CHANNELS=4, vector {0x3F800000, 0x40000000, 0xC0400000, 0x3F000000} (1.0, 2.0, -3.0, 0.5) -> o_valid on cycle 3, o_data=0x40000000, o_index=1.
- CHANNELS=5, vector {-1.0 0xBF800000, -0.5 0xBF000000, -2.0 0xC0000000, -4.0 0xC0800000, 3.0 0x40400000} -> odd pass-through exercised, R=3, o_valid on cycle 4, o_data=0x40400000, o_index=4.
- CHANNELS=4, ties {2.0, 1.0, 2.0, 2.0} -> o_data=0x40000000, o_index=0. Also check +0 (0x00000000) vs -0 (0x80000000) at indices 0 and 1 -> o_index=0.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid, o_data and o_index stay constant and o_ready=0. Assert i_ready -> IDLE next cycle and o_ready=1.
- Reset with rst_n=0 during the second REDUCE round -> next cycle state IDLE, o_valid=0, o_busy=0. A new request {0.5, 1.0, 0, 0} then yields o_data=0x3F800000, o_index=1.
- CHANNELS=1, input 0xC0400000 -> o_valid one cycle after acceptance, o_data=0xC0400000, o_index=0.
